posit_encode_pipe: RTL and testbench

- Pipelined posit field packer, the inverse of the posit field extractor used in the posit-to-float path.
- Accepts decoded fields: sign, signed regime value k, exponent, fraction and sticky.
- Produces a correctly rounded N-bit posit (round-to-nearest-even).
- Sits at the back end of the float-to-posit converter and the posit arithmetic units; valid/ready streaming on both sides.

---
 rtl/posit_pkg.sv | 46 ++++
 rtl/DSR_right_N_S.sv | 18 +
 rtl/posit_encode_pipe.sv | 126 ++++++++++++
 tb/tb_posit_encode_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit encoder definitions: default word geometry, special encodings
// and the per-stage payload types carried through the encode pipeline.
package posit_pkg;

  function automatic int log2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int POSIT_N  = 16;
  localparam int POSIT_ES = 2;
  localparam int POSIT_BS = log2(POSIT_N);

  localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] ZERO   = '0;
  localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
  localparam logic [POSIT_N-1:0] MINPOS = {{(POSIT_N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    SP_NONE,
    SP_ZERO,
    SP_NAR,
    SP_MAXPOS,
    SP_MINPOS
  } special_t;

  typedef struct packed {
    logic                       valid;
    special_t                   special;
    logic                       sign;
    logic [POSIT_BS-1:0]        r;
    logic                       polarity;
    logic [POSIT_ES-1:0]        exp;
    logic [POSIT_N-POSIT_ES-1:0] mant;
    logic                       sticky;
  } s1_payload_t;

  typedef struct packed {
    logic               valid;
    special_t           special;
    logic               sign;
    logic [POSIT_N-2:0] mag;
  } s2_payload_t;

endpackage

// File: rtl/DSR_right_N_S.sv
// Dynamic logarithmic right shifter: c = a >> b, zero fill.
module DSR_right_N_S #(
  parameter int N = 32,
  parameter int S = 5
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c
);

  always_comb begin
    c = a;
    for (int i = 0; i < S; i++) begin
      if (b[i]) c = c >> (2 ** i);
    end
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage posit packer: classify/regime, shift/round-to-nearest-even,
// then sign and special substitution, with a stall-aware valid/ready chain.
module posit_encode_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int es = POSIT_ES,
  parameter int Bs = log2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [Bs:0]   in_k,
  input  logic [es-1:0] in_exp,
  input  logic [N-es-1:0] in_mant,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  localparam logic signed [Bs:0] K_MAX = (Bs+1)'(N - 2);
  localparam logic signed [Bs:0] K_MIN = (Bs+1)'(-(N - 2));

  s1_payload_t s1_reg, s1_next;
  s2_payload_t s2_reg, s2_next;
  logic         s3_valid_reg;
  logic [N-1:0] s3_posit_reg, s3_posit_next;
  logic         en1, en2, en3;

  assign en3      = !s3_valid_reg | out_ready;
  assign en2      = !s2_reg.valid | en3;
  assign en1      = !s1_reg.valid | en2;
  assign in_ready = en1;

  // S1: classify and derive the regime run length
  logic signed [Bs:0] k;
  assign k = signed'(in_k);

  always_comb begin
    s1_next          = '0;
    s1_next.valid    = in_valid;
    s1_next.sign     = in_sign;
    s1_next.exp      = in_exp;
    s1_next.mant     = in_mant;
    s1_next.sticky   = in_sticky;
    s1_next.polarity = ~in_k[Bs];
    s1_next.special  = SP_NONE;
    if (in_nar)            s1_next.special = SP_NAR;
    else if (in_zero)      s1_next.special = SP_ZERO;
    else if (k >= K_MAX)   s1_next.special = SP_MAXPOS;
    else if (k < K_MIN)    s1_next.special = SP_MINPOS;
    // Low Bs bits suffice: saturated cases never use r
    if (in_k[Bs]) s1_next.r = ~in_k[Bs-1:0] + Bs'(1);
    else          s1_next.r = in_k[Bs-1:0] + Bs'(1);
  end

  // S2: place {exp,mant} behind the regime and round
  logic [2*N-1:0] shift_in, shifted, regime, str;
  logic [Bs-1:0]  shamt;
  logic [N-2:0]   mag;
  logic           guard, sticky, round_up;

  assign shift_in = {s1_reg.exp, s1_reg.mant, {N{1'b0}}};
  assign shamt    = s1_reg.r + Bs'(1);

  DSR_right_N_S #(.N(2*N), .S(Bs)) u_dsr (
    .a(shift_in),
    .b(shamt),
    .c(shifted)
  );

  always_comb begin
    regime   = s1_reg.polarity ? ~({(2*N){1'b1}} >> s1_reg.r)
                               : ({1'b1, {(2*N-1){1'b0}}} >> s1_reg.r);
    str      = regime | shifted;
    mag      = str[2*N-1:N+1];
    guard    = str[N];
    sticky   = (|str[N-1:0]) | s1_reg.sticky;
    round_up = guard & (mag[0] | sticky);

    s2_next         = '0;
    s2_next.valid   = s1_reg.valid;
    s2_next.special = s1_reg.special;
    s2_next.sign    = s1_reg.sign;
    case (s1_reg.special)
      SP_MAXPOS: s2_next.mag = MAXPOS[N-2:0];
      SP_MINPOS: s2_next.mag = MINPOS[N-2:0];
      default:   s2_next.mag = mag + {{(N-2){1'b0}}, round_up};
    endcase
  end

  // S3: apply sign; NaR and zero bypass the magnitude path
  logic [N-1:0] mag_w;
  assign mag_w = {1'b0, s2_reg.mag};

  always_comb begin
    s3_posit_next = s2_reg.sign ? -mag_w : mag_w;
    if (s2_reg.special == SP_NAR)       s3_posit_next = NAR;
    else if (s2_reg.special == SP_ZERO) s3_posit_next = ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg       <= '0;
      s2_reg       <= '0;
      s3_valid_reg <= 1'b0;
      s3_posit_reg <= '0;
    end else begin
      if (en1) s1_reg <= s1_next;
      if (en2) s2_reg <= s2_next;
      if (en3) begin
        s3_valid_reg <= s2_reg.valid;
        s3_posit_reg <= s3_posit_next;
      end
    end
  end

  assign out_valid = s3_valid_reg;
  assign out_posit = s3_posit_reg;

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Scoreboard bench for posit_encode_pipe: a driver pushes hand-computed
// expected posits, an independent monitor pops and compares on every output.
module tb_posit_encode_pipe;

  localparam int N  = 16;
  localparam int ES = 2;
  localparam int BS = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, in_sign, in_zero, in_nar, in_sticky;
  logic [BS:0]   in_k;
  logic [ES-1:0] in_exp;
  logic [N-ES-1:0] in_mant;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_posit;

  posit_encode_pipe #(.N(N), .es(ES), .Bs(BS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar),
    .in_k(in_k), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] posit;
    int          cyc;
    bit          chk;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accepted = 0;
  bit   stalled = 0;
  logic [15:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic s, input logic z, input logic n, input logic [4:0] k,
                      input logic [1:0] e, input logic [13:0] m, input logic st,
                      input logic [15:0] expv, input bit chk, input string name);
    int waits = 0;
    in_valid = 1'b1; in_sign = s; in_zero = z; in_nar = n;
    in_k = k; in_exp = e; in_mant = m; in_sticky = st;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout %s actual=in_ready_low required=accept", name);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    sb.push_back('{expv, cyc, chk, name});
    accepted++;
    $display("IN  %-16s s=%0b z=%0b n=%0b k=%0d e=%0d m=%h st=%0b expect=%h",
             name, s, z, n, $signed(k), e, m, st, expv);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drain"}, sb.size(), 0);
  endtask

  // Monitor: compare every presented output and verify holds during stalls
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          check("stall_hold_valid", 32'(out_valid), 32'd1);
          check("stall_hold_posit", 32'(out_posit), 32'(held));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=%h required=none", out_posit);
          end else begin
            e = sb.pop_front();
            check(e.name, 32'(out_posit), 32'(e.posit));
            if (e.chk) check({e.name, "_latency"}, 32'(cyc + 1 - e.cyc), 32'd3);
            $display("OUT %-16s posit=%h expect=%h", e.name, out_posit, e.posit);
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_posit;
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    in_k = '0; in_exp = '0; in_mant = '0; in_sticky = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_posit", 32'(out_posit), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors, streamed back to back
    send(0, 0, 0, 5'd0,  2'd0, 14'h0000, 0, 16'h4000, 1, "k0");
    send(1, 0, 0, 5'd0,  2'd0, 14'h0000, 0, 16'hC000, 1, "k0_neg");
    send(0, 0, 0, 5'h1F, 2'd3, 14'h0000, 0, 16'h3800, 1, "km1_e3");
    send(1, 0, 0, 5'h1F, 2'd3, 14'h0000, 0, 16'hC800, 1, "km1_e3_neg");
    send(0, 0, 0, 5'd2,  2'd1, 14'h2000, 0, 16'h7300, 1, "k2_e1");
    send(0, 0, 0, 5'd0,  2'd0, 14'b00000000001100, 0, 16'h4002, 1, "rnd_up");
    send(1, 0, 0, 5'd0,  2'd0, 14'b00000000001100, 0, 16'hBFFE, 1, "rnd_up_neg");
    send(0, 0, 0, 5'd0,  2'd0, 14'b00000000000100, 0, 16'h4000, 1, "rnd_tie_even");
    send(0, 0, 0, 5'd0,  2'd0, 14'b00000000000100, 1, 16'h4001, 1, "rnd_sticky");
    send(0, 0, 0, 5'd15, 2'd0, 14'h0000, 0, 16'h7FFF, 1, "sat_max");
    send(0, 0, 0, 5'd14, 2'd0, 14'h0000, 0, 16'h7FFF, 1, "sat_max_edge");
    send(1, 0, 0, 5'd15, 2'd0, 14'h0000, 0, 16'h8001, 1, "sat_max_neg");
    send(0, 0, 0, 5'h10, 2'd0, 14'h0000, 0, 16'h0001, 1, "sat_min");
    send(1, 0, 0, 5'h10, 2'd0, 14'h0000, 0, 16'hFFFF, 1, "sat_min_neg");
    send(0, 0, 0, 5'd13, 2'd3, 14'h0000, 0, 16'h7FFF, 1, "k13_round_max");
    send(0, 0, 0, 5'h12, 2'd2, 14'h0000, 0, 16'h0002, 1, "km14_round");
    send(0, 0, 0, 5'h12, 2'd1, 14'h0000, 0, 16'h0001, 1, "km14_no_round");
    send(0, 1, 1, 5'd3,  2'd1, 14'h1234, 1, 16'h8000, 1, "nar");
    send(1, 1, 0, 5'd3,  2'd1, 14'h1234, 1, 16'h0000, 1, "zero");
    in_valid = 1'b0;
    drain("directed");

    // Backpressure: output stalled while a 6-item burst is offered
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(0, 0, 0, 5'd0, 2'd0, 14'(i << 3), 0, 16'h4000 | 16'(i), 0, "bp_item");
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_accepted_while_stalled", 32'(accepted), 32'd3);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure");
    check("bp_total_accepted", 32'(accepted), 32'd6);

    // Reset with three items in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, 0, 0, 5'd0, 2'd0, 14'h0000, 0, 16'h4000, 0, "flush_item");
    in_valid = 1'b0;
    #2;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_out_posit", 32'(out_posit), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_no_stale", 32'(out_valid), 32'd0);
    send(0, 0, 0, 5'h1F, 2'd3, 14'h0000, 0, 16'h3800, 1, "post_reset");
    in_valid = 1'b0;
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
